// File: rtl/load_rotate_ctrl_pkg.sv
// Shared types and helpers for the load-then-rotate controller:
// state encodings, rotate direction codes and step-counter sizing.
package load_rotate_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        ROTATE  = 2'd2,
        ILLEGAL = 2'd3
    } state_e;

    localparam logic ROT_INC = 1'b0;
    localparam logic ROT_DEC = 1'b1;

    // Step counter must hold the value ROT_CYCLES; never narrower than 1 bit.
    function automatic int step_width(input int rot_cycles);
        return (rot_cycles > 0) ? $clog2(rot_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/mod_updown_cnt.sv
// Modulo-MOD up/down counter with synchronous clear; wraps by explicit
// compare so MOD need not be a power of two.
module mod_updown_cnt
    import load_rotate_ctrl_pkg::*;
#(
    parameter int MOD = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    dir,
    output logic [$clog2(MOD)-1:0]  cnt
);

    localparam int            W    = $clog2(MOD);
    localparam logic [W-1:0]  LAST = W'(MOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        // NOTE: assign the default first so every path drives cnt_d; no latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (dir == ROT_DEC) begin
                cnt_d = (cnt_q == '0) ? LAST : cnt_q - W'(1);
            end else begin
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment only.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/load_rotate_ctrl.sv
// Sequences DEPTH slot writes, then drives a modulo-DEPTH rotation pointer,
// with pause, direction, clear, reload and an optional bounded rotate run.
module load_rotate_ctrl
    import load_rotate_ctrl_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ROT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_rotate,
    input  logic                      dir,
    input  logic                      pause,
    input  logic                      clear,
    output logic [1:0]                state,
    output logic [$clog2(DEPTH)-1:0]  load_position,
    output logic                      load_en,
    output logic [$clog2(DEPTH)-1:0]  rot_ptr,
    output logic                      done
);

    localparam int                 PW        = $clog2(DEPTH);
    localparam int                 STEP_W    = step_width(ROT_CYCLES);
    localparam logic [PW-1:0]      LAST_POS  = PW'(DEPTH - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST = (ROT_CYCLES > 0) ? STEP_W'(ROT_CYCLES - 1) : '0;

    state_e              state_q, state_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                done_q, done_d;
    logic                rot_clr;
    logic                rot_en;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        step_d  = step_q;
        done_d  = 1'b0;
        rot_clr = 1'b0;
        rot_en  = 1'b0;

        if (clear) begin
            state_d = IDLE;
            pos_d   = '0;
            step_d  = '0;
            rot_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // rot_ptr keeps its last value in IDLE and is zeroed on LOAD entry.
                    if (load_rotate) begin
                        state_d = LOAD;
                        pos_d   = '0;
                        rot_clr = 1'b1;
                    end
                end
                LOAD: begin
                    if (load_rotate) begin
                        if (pos_q == LAST_POS) begin
                            state_d = ROTATE;
                            pos_d   = '0;
                            step_d  = '0;
                            rot_clr = 1'b1;
                        end else begin
                            pos_d = pos_q + PW'(1);
                        end
                    end
                end
                ROTATE: begin
                    pos_d = '0;
                    if (load_rotate) begin
                        state_d = LOAD;
                        step_d  = '0;
                        rot_clr = 1'b1;
                    end else if (!pause) begin
                        rot_en = 1'b1;
                        // The completing step still moves rot_ptr on the same edge.
                        if (ROT_CYCLES > 0) begin
                            if (step_q == STEP_LAST) begin
                                state_d = IDLE;
                                step_d  = '0;
                                done_d  = 1'b1;
                            end else begin
                                step_d = step_q + STEP_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    pos_d   = '0;
                    step_d  = '0;
                    rot_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    mod_updown_cnt #(
        .MOD (DEPTH)
    ) u_rot_cnt (
        .clk (clk),
        .rst (rst),
        .clr (rot_clr),
        .en  (rot_en),
        .dir (dir),
        .cnt (rot_ptr)
    );

    assign state         = state_q;
    assign load_position = pos_q;
    assign done          = done_q;
    assign load_en       = (state_q == LOAD) && load_rotate && !clear;

endmodule

// File: tb/tb_load_rotate_ctrl.sv
// Bench for load_rotate_ctrl: three configurations (8/unbounded, 5/unbounded,
// 5/bounded-3) compared every cycle against a behavioural reference model.
module tb_load_rotate_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       lr [3];
    logic       dr [3];
    logic       ps [3];
    logic       cl [3];
    logic [1:0] st [3];
    logic [2:0] lp [3];
    logic [2:0] rp [3];
    logic       le [3];
    logic       dn [3];

    load_rotate_ctrl #(.DEPTH(8), .ROT_CYCLES(0)) u_d8 (
        .clk(clk), .rst(rst), .load_rotate(lr[0]), .dir(dr[0]), .pause(ps[0]), .clear(cl[0]),
        .state(st[0]), .load_position(lp[0]), .load_en(le[0]), .rot_ptr(rp[0]), .done(dn[0]));

    load_rotate_ctrl #(.DEPTH(5), .ROT_CYCLES(0)) u_d5 (
        .clk(clk), .rst(rst), .load_rotate(lr[1]), .dir(dr[1]), .pause(ps[1]), .clear(cl[1]),
        .state(st[1]), .load_position(lp[1]), .load_en(le[1]), .rot_ptr(rp[1]), .done(dn[1]));

    load_rotate_ctrl #(.DEPTH(5), .ROT_CYCLES(3)) u_d5_b3 (
        .clk(clk), .rst(rst), .load_rotate(lr[2]), .dir(dr[2]), .pause(ps[2]), .clear(cl[2]),
        .state(st[2]), .load_position(lp[2]), .load_en(le[2]), .rot_ptr(rp[2]), .done(dn[2]));

    // Reference model: phase 0=idle, 1=loading, 2=rotating; plain modulo arithmetic.
    typedef struct {
        int phase;
        int slot;
        int offset;
        int steps;
        int pulse;
    } mdl_t;

    mdl_t m [3];
    int   dep [3] = '{8, 5, 5};
    int   rcy [3] = '{0, 0, 3};

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.phase = 0; z.slot = 0; z.offset = 0; z.steps = 0; z.pulse = 0;
        return z;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t c, input int depth, input int runlen,
                                      input logic load, input logic down, input logic hold,
                                      input logic abort);
        mdl_t n = c;
        n.pulse = 0;
        if (abort) return mdl_zero();
        if (c.phase == 0) begin
            if (load) begin n.phase = 1; n.slot = 0; n.offset = 0; end
        end else if (c.phase == 1) begin
            if (load) begin
                if (c.slot == depth - 1) begin
                    n.phase = 2; n.slot = 0; n.offset = 0; n.steps = 0;
                end else begin
                    n.slot = c.slot + 1;
                end
            end
        end else begin
            n.slot = 0;
            if (load) begin
                n.phase = 1; n.offset = 0; n.steps = 0;
            end else if (!hold) begin
                n.offset = down ? (c.offset + depth - 1) % depth : (c.offset + 1) % depth;
                n.steps  = c.steps + 1;
                if (runlen > 0 && n.steps == runlen) begin
                    n.phase = 0; n.steps = 0; n.pulse = 1;
                end
            end
        end
        return n;
    endfunction

    task automatic tick();
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("i%0d load_en", i), le[i], (m[i].phase == 1 && lr[i] && !cl[i]) ? 1 : 0);
        @(posedge clk);
        for (int i = 0; i < 3; i++)
            m[i] = mdl_next(m[i], dep[i], rcy[i], lr[i], dr[i], ps[i], cl[i]);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("i%0d state", i),    st[i], m[i].phase);
            check($sformatf("i%0d load_pos", i), lp[i], m[i].slot);
            check($sformatf("i%0d rot_ptr", i),  rp[i], m[i].offset);
            check($sformatf("i%0d done", i),     dn[i], m[i].pulse);
        end
        @(negedge clk);
    endtask

    // Reset pulsed between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("i%0d arst state", i),   st[i], 0);
            check($sformatf("i%0d arst pos", i),     lp[i], 0);
            check($sformatf("i%0d arst rot_ptr", i), rp[i], 0);
            check($sformatf("i%0d arst done", i),    dn[i], 0);
            check($sformatf("i%0d arst load_en", i), le[i], 0);
            m[i] = mdl_zero();
        end
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic quiet();
        for (int i = 0; i < 3; i++) begin
            lr[i] = 1'b0; dr[i] = 1'b0; ps[i] = 1'b0; cl[i] = 1'b0;
        end
    endtask

    initial begin
        int seq5 [5] = '{4, 3, 2, 1, 0};
        rst = 1'b1;
        quiet();
        for (int i = 0; i < 3; i++) m[i] = mdl_zero();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("i%0d reset state", i),   st[i], 0);
            check($sformatf("i%0d reset pos", i),     lp[i], 0);
            check($sformatf("i%0d reset rot_ptr", i), rp[i], 0);
            check($sformatf("i%0d reset done", i),    dn[i], 0);
        end
        rst = 1'b0;

        // DEPTH=8 unbounded: enter LOAD, 8 writes, then rotate through the wrap.
        lr[0] = 1'b1;
        tick();
        check("d8 enter LOAD", st[0], 1);
        for (int k = 0; k < 8; k++) begin
            #1;
            check("d8 load_en high", le[0], 1);
            check("d8 slot index", lp[0], k);
            tick();
        end
        check("d8 in ROTATE", st[0], 2);
        lr[0] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("d8 rot step", rp[0], k % 8);
        end

        // DEPTH=5 unbounded, decrementing, then a direction flip.
        lr[1] = 1'b1; dr[1] = 1'b1;
        repeat (6) tick();
        lr[1] = 1'b0;
        check("d5 in ROTATE", st[1], 2);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("d5 dec step", rp[1], seq5[k]);
        end
        dr[1] = 1'b0;
        tick();
        check("d5 flip inc", rp[1], 1);

        // DEPTH=5 bounded to 3 steps with a 2-cycle pause after the first step.
        lr[2] = 1'b1;
        repeat (6) tick();
        lr[2] = 1'b0;
        tick();
        check("b3 first step", rp[2], 1);
        ps[2] = 1'b1;
        tick();
        tick();
        check("b3 paused ptr", rp[2], 1);
        check("b3 paused state", st[2], 2);
        ps[2] = 1'b0;
        tick();
        check("b3 second step", rp[2], 2);
        check("b3 no early done", dn[2], 0);
        tick();
        check("b3 final ptr", rp[2], 3);
        check("b3 done pulse", dn[2], 1);
        check("b3 back to IDLE", st[2], 0);
        tick();
        check("b3 done cleared", dn[2], 0);
        check("b3 ptr held in IDLE", rp[2], 3);

        // Reload on the final-step cycle overrides completion.
        lr[2] = 1'b1;
        repeat (6) tick();
        lr[2] = 1'b0;
        repeat (2) tick();
        lr[2] = 1'b1;
        tick();
        check("reload state", st[2], 1);
        check("reload pos", lp[2], 0);
        check("reload rot_ptr", rp[2], 0);
        check("reload no done", dn[2], 0);
        lr[2] = 1'b0;

        // clear together with a strobe mid-LOAD.
        cl[0] = 1'b1;
        tick();
        cl[0] = 1'b0;
        lr[0] = 1'b1;
        repeat (5) tick();
        check("clr at pos 4", lp[0], 4);
        cl[0] = 1'b1;
        #1;
        check("clr blocks load_en", le[0], 0);
        tick();
        check("clr state", st[0], 0);
        check("clr pos", lp[0], 0);
        check("clr rot_ptr", rp[0], 0);
        cl[0] = 1'b0;

        // Asynchronous reset during ROTATE, then a fresh load sequence.
        repeat (9) tick();
        lr[0] = 1'b0;
        repeat (3) tick();
        check("pre-rst rot_ptr", rp[0], 3);
        async_reset();
        lr[0] = 1'b1;
        repeat (9) tick();
        check("post-rst ROTATE", st[0], 2);
        lr[0] = 1'b0;
        repeat (3) tick();
        check("post-rst rot_ptr", rp[0], 3);

        // Randomised traffic against the model.
        repeat (600) begin
            for (int i = 0; i < 3; i++) begin
                lr[i] = ($urandom_range(99) < 25);
                dr[i] = $urandom_range(1);
                ps[i] = ($urandom_range(99) < 20);
                cl[i] = ($urandom_range(99) < 3);
            end
            if ($urandom_range(199) == 0) async_reset();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_rotate_ctrl.md
Name: load_rotate_ctrl

Overview:
Parametrised controller for the load-then-rotate datapath: it sequences DEPTH slot writes, then drives a modulo-DEPTH rotation pointer.
- Adds over the current fixed-8-slot controller: selectable rotate direction, pause, synchronous clear, reload from ROTATE, and an optional bounded rotate run with a done pulse.
- Sits between the top-level button/strobe logic and the slot register bank / display mux.

Parameters:
DEPTH, 8, number of load slots and rotation modulus; legal range 2..256, need not be a power of 2.
ROT_CYCLES, 0, rotate steps before returning to IDLE; 0 = rotate indefinitely.
PW, $clog2(DEPTH), localparam, pointer width (not overridable).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
load_rotate  in  1  load/advance strobe, one slot per high cycle
dir  in  1  rotate direction: 0 = increment rot_ptr, 1 = decrement
pause  in  1  freezes rotation while high
clear  in  1  synchronous abort to IDLE
state  out  2  current state, encodings from head.v
load_position  out  PW  slot index being written
load_en  out  1  write enable for slot load_position this cycle
rot_ptr  out  PW  current rotation offset
done  out  1  one-cycle pulse when a bounded rotate run completes

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, load_position=0, rot_ptr=0, done=0, step counter=0.
- Registered outputs: state, load_position, rot_ptr, done. Combinational output: load_en = (state==LOAD) && load_rotate && !clear.
- Encodings: IDLE=2'd0, LOAD=2'd1, ROTATE=2'd2. Encoding 2'd3 is illegal and goes to IDLE with all registers zeroed on the next edge.
- Per-edge priority: rst > clear > state logic. clear=1 in any state gives next state IDLE with load_position, rot_ptr, step counter and done all 0.
- IDLE:
  - load_rotate=1 -> LOAD, load_position=0. No slot is written in this cycle (load_en=0).
  - Otherwise hold.
- LOAD:
  - load_rotate=1: slot load_position is written. If load_position==DEPTH-1, go to ROTATE with load_position=0, rot_ptr=0, step=0. Otherwise load_position+1.
  - load_rotate=0: hold all registers.
  - Exactly DEPTH strobes in LOAD are needed to enter ROTATE.
- ROTATE:
  - load_position is held at 0.
  - If load_rotate=1 (reload): go to LOAD with load_position=0, rot_ptr=0, step=0. This overrides any step or completion in the same cycle, and done stays 0.
  - Else if pause=1: hold rot_ptr and step. Paused cycles do not count.
  - Else take one step per cycle:
    - dir=0: rot_ptr = (rot_ptr==DEPTH-1) ? 0 : rot_ptr+1.
    - dir=1: rot_ptr = (rot_ptr==0) ? DEPTH-1 : rot_ptr-1.
    - dir is sampled every cycle; changing it mid-run reverses direction on the next step.
  - Bounded run (ROT_CYCLES>0): step increments per step. The step that makes step==ROT_CYCLES is still applied to rot_ptr, and on the same edge state goes to IDLE and done is set to 1 for exactly one cycle. rot_ptr keeps its final value in IDLE until the next LOAD entry.
  - Unbounded run (ROT_CYCLES==0): no step counter, done is never asserted, and ROTATE is left only by reload, clear or rst.
- Widths: step counter is $clog2(ROT_CYCLES+1) bits with a minimum of 1. All pointer arithmetic is PW bits, with explicit wrap compares, never relying on natural overflow.
- rst asserted mid-operation clears everything immediately. After deassertion the block waits in IDLE for a fresh load_rotate.

Decomposition:
- head.v (shared header) gains `ROT_INC=1'b0 and `ROT_DEC=1'b1 alongside the existing `IDLE/`LOAD/`ROTATE. An `ILLEGAL=2'd3 define is added for the verification bench's coverage.
- One sub-module: mod_updown_cnt (parameter MOD; inputs clk, rst, clr, en, dir; output cnt), used for rot_ptr.
- The FSM and load counter stay in load_rotate_ctrl.

Test Plan:
- DEPTH=8, ROT_CYCLES=0: 1 strobe in IDLE, then 8 strobes -> load_en high on exactly 8 cycles with load_position 0..7; state=ROTATE after the 8th; rot_ptr steps 0,1,...,7,0 (wrap).
- DEPTH=5, ROT_CYCLES=0, dir=1 in ROTATE -> rot_ptr sequence 0,4,3,2,1,0; dir flipped to 0 mid-run -> next step is +1.
- DEPTH=5, ROT_CYCLES=3, pause high for 2 cycles after the first step -> rot_ptr 1,1,1,2,3; done pulses once on the edge where rot_ptr becomes 3; state=IDLE in the same cycle.
- ROTATE with ROT_CYCLES=3 and load_rotate asserted on the final-step cycle -> state=LOAD, load_position=0, rot_ptr=0, done stays 0.
- clear asserted mid-LOAD (load_position=4) together with load_rotate -> load_en=0, next state IDLE with all outputs 0.
- rst pulsed asynchronously between clock edges during ROTATE -> outputs zero without waiting for a clock edge; a fresh load sequence afterwards behaves as the first scenario.
